phy_rx_lane_sync_ctrl: RTL
==========================

// Module: phy_rx_lane_sync_ctrl
// PURPOSE
//  Sequencing controller for the 2-lane PHY RX path. Hunts for the COMMA symbol on each serial lane
//  (clk_32f bit rate) and byte-aligns each lane after COMMA_COUNT consecutive aligned commas.
//  Measures inter-lane skew and programs per-lane delay taps for the RX datapath.
//  Then asserts rx_enable and a byte strobe so the datapath can assemble deskewed bytes.
// PARAMETERS
//  COMMA        8'hBC  alignment symbol, MSB received first
//  COMMA_COUNT  4      consecutive byte-aligned commas required to lock a lane
//  MAX_SKEW     7      max tolerated skew between lanes, in bit times (clk_32f cycles)
//  SEL_W        3      width of delay_sel_*; must hold MAX_SKEW
// PORTS
//  clk_32f      in   1      bit-rate clock, all logic on posedge
//  reset        in   1      synchronous, active-high
//  data_in_0    in   1      serial lane 0
//  data_in_1    in   1      serial lane 1
//  realign      in   1      1-cycle pulse: drop lock and re-hunt both lanes
//  lane_locked  out  2      per-lane byte lock, bit i = lane i
//  delay_sel_0  out  SEL_W  bits of delay the datapath applies to lane 0
//  delay_sel_1  out  SEL_W  bits of delay the datapath applies to lane 1
//  rx_enable    out  1      both lanes locked and deskewed
//  byte_strobe  out  1      1-cycle pulse per deskewed byte boundary
//  deskew_err   out  1      1-cycle pulse: skew exceeded MAX_SKEW
// BEHAVIOUR
//  Reset, or realign, takes effect on the next edge. All outputs go to 0, lanes enter HUNT, deskew FSM enters IDLE.
//  Per lane: 8-bit shift reg sr <= {sr[6:0], data_in_i} every cycle; comma_hit = (sr == COMMA).
//  Lane FSM, with bit_cnt (3b) and com_cnt:
//   HUNT:   comma_hit -> ALIGN; com_cnt=1, bit_cnt=1. bit_cnt wraps 7->0.
//           A boundary is any cycle with bit_cnt==0, i.e. every 8 cycles after the hit.
//   ALIGN:  at a boundary, comma_hit -> com_cnt+1; else -> HUNT with com_cnt=0.
//           Reaching COMMA_COUNT -> LOCKED, and lane_locked[i]=1 on the following cycle.
//           Off-boundary comma_hit is ignored.
//   LOCKED: bit_cnt keeps running. The lane leaves only on reset, realign or deskew error; data content is not checked.
//  Deskew FSM, with skew_cnt (SEL_W+1 bits):
//   IDLE: both lanes lock in the same cycle -> DONE, skew 0.
//         One lane locks -> WAIT, skew_cnt=0, first=that lane.
//   WAIT: skew_cnt+1 per cycle. Other lane locks -> DONE.
//         The earlier lane's delay_sel = skew_cnt at that cycle; the later lane's = 0.
//         skew_cnt > MAX_SKEW -> deskew_err=1 for one cycle, both lanes -> HUNT, lane_locked=0, -> IDLE.
//   DONE: rx_enable=1 from the cycle after entry. delay_sel_* held constant.
//         byte_strobe=1 on each boundary of the later-locking lane (lane 0 if simultaneous).
//  delay_sel_* change only on entry to DONE, or clear to 0 on reset, realign or error.
//  Simultaneous realign and lock: realign wins.
//  Bit timing: the datapath delays lane i by delay_sel_i flops. After that delay, lane boundaries coincide with byte_strobe.
// TESTING
//  1. Both lanes: 4x 8'hBC in phase -> lane_locked 2'b00->2'b11 in the same cycle; delay_sel_0=delay_sel_1=0; rx_enable next cycle.
//  2. Lane 1 = lane 0 delayed 4 cycles, 4x 8'hBC then AA/55/66 -> lane_locked[0] set 4 cycles before [1];
//     delay_sel_0=4, delay_sel_1=0; byte_strobe every 8 cycles at lane 1 boundaries.
//  3. Lane 1 delayed 9 cycles (MAX_SKEW=7) -> deskew_err one pulse; lane_locked=2'b00; rx_enable stays 0; relocks when skew fixed.
//  4. Lane 0: 3x 8'hBC then 8'hAA -> lane 0 never locks; returns to HUNT; a later run of 4x 8'hBC locks it.
//  5. 3 junk bits (101) before 4x 8'hBC on both lanes -> locks at the correct bit phase; byte_strobe after the last BC bit.
//  6. realign pulse, then reset, while in DONE -> next cycle all outputs 0; 4x 8'hBC re-acquires lock.

Source files
------------

// File: rtl/phy_rx_lane_sync_ctrl.sv
// Two-lane RX sync controller: per-lane comma hunt and byte lock, then inter-lane skew
// measurement, delay tap programming, and a byte strobe on the later lane's byte boundaries.
module phy_rx_lane_sync_ctrl #(
    parameter logic [7:0]  COMMA       = 8'hBC,
    parameter int unsigned COMMA_COUNT = 4,
    parameter int unsigned MAX_SKEW    = 7,
    parameter int unsigned SEL_W       = 3
) (
    input  logic             clk_32f,
    input  logic             reset,
    input  logic             data_in_0,
    input  logic             data_in_1,
    input  logic             realign,
    output logic [1:0]       lane_locked,
    output logic [SEL_W-1:0] delay_sel_0,
    output logic [SEL_W-1:0] delay_sel_1,
    output logic             rx_enable,
    output logic             byte_strobe,
    output logic             deskew_err
);

    localparam int unsigned CNT_W  = $clog2(COMMA_COUNT + 1);
    localparam int unsigned SKEW_W = SEL_W + 1;

    typedef enum logic [1:0] {LnHunt, LnAlign, LnLocked} lane_state_e;
    typedef enum logic [1:0] {DsIdle, DsWait, DsDone} dsk_state_e;

    logic [1:0] din;
    logic       clear;
    logic       err_now;
    logic [1:0] comma_hit, boundary, lock_evt, lock_ok;

    logic [1:0][7:0]       sr_q;
    logic [1:0][2:0]       bit_cnt_q, bit_cnt_d;
    logic [1:0][CNT_W-1:0] com_cnt_q, com_cnt_d;
    lane_state_e           lane_q [2];
    lane_state_e           lane_d [2];

    dsk_state_e        dsk_q, dsk_d;
    logic [SKEW_W-1:0] skew_q, skew_d, skew_nxt;
    logic              first_q, first_d;
    logic [SEL_W-1:0]  sel0_q, sel0_d, sel1_q, sel1_d;
    logic              rx_en_q, err_q;

    assign din   = {data_in_1, data_in_0};
    assign clear = reset | realign;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            comma_hit[i] = (sr_q[i] == COMMA);
            boundary[i]  = (bit_cnt_q[i] == 3'd0);
            lock_evt[i]  = (lane_q[i] == LnAlign) && boundary[i] && comma_hit[i] &&
                           (com_cnt_q[i] == CNT_W'(COMMA_COUNT - 1));
        end
        // A realign in the same cycle as a lock discards the lock.
        lock_ok = lock_evt & {2{~clear}};
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            lane_d[i]    = lane_q[i];
            bit_cnt_d[i] = bit_cnt_q[i] + 3'd1;
            com_cnt_d[i] = com_cnt_q[i];
            unique case (lane_q[i])
                LnHunt: begin
                    if (comma_hit[i]) begin
                        lane_d[i]    = LnAlign;
                        com_cnt_d[i] = CNT_W'(1);
                        bit_cnt_d[i] = 3'd1;
                    end
                end
                LnAlign: begin
                    if (boundary[i]) begin
                        if (comma_hit[i]) begin
                            com_cnt_d[i] = com_cnt_q[i] + CNT_W'(1);
                            if (lock_evt[i]) lane_d[i] = LnLocked;
                        end else begin
                            lane_d[i]    = LnHunt;
                            com_cnt_d[i] = '0;
                        end
                    end
                end
                LnLocked: lane_d[i] = LnLocked;
                default:  lane_d[i] = LnHunt;
            endcase
            if (clear || err_now) begin
                lane_d[i]    = LnHunt;
                com_cnt_d[i] = '0;
            end
        end
    end

    always_comb begin
        dsk_d    = dsk_q;
        skew_d   = skew_q;
        first_d  = first_q;
        sel0_d   = sel0_q;
        sel1_d   = sel1_q;
        err_now  = 1'b0;
        skew_nxt = skew_q + SKEW_W'(1);
        unique case (dsk_q)
            DsIdle: begin
                if (&lock_ok) begin
                    // first_q = 1 makes lane 0 the strobe lane for a simultaneous lock.
                    dsk_d   = DsDone;
                    first_d = 1'b1;
                    sel0_d  = '0;
                    sel1_d  = '0;
                end else if (|lock_ok) begin
                    dsk_d   = DsWait;
                    skew_d  = '0;
                    first_d = lock_ok[1];
                end
            end
            DsWait: begin
                skew_d = skew_nxt;
                if (skew_nxt > SKEW_W'(MAX_SKEW)) begin
                    err_now = 1'b1;
                    dsk_d   = DsIdle;
                    sel0_d  = '0;
                    sel1_d  = '0;
                end else if (lock_ok[~first_q]) begin
                    dsk_d = DsDone;
                    if (first_q) begin
                        sel0_d = '0;
                        sel1_d = skew_nxt[SEL_W-1:0];
                    end else begin
                        sel0_d = skew_nxt[SEL_W-1:0];
                        sel1_d = '0;
                    end
                end
            end
            DsDone:  dsk_d = DsDone;
            default: dsk_d = DsIdle;
        endcase
        if (clear) begin
            dsk_d  = DsIdle;
            skew_d = '0;
            sel0_d = '0;
            sel1_d = '0;
        end
    end

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            sr_q      <= '0;
            bit_cnt_q <= '0;
            com_cnt_q <= '0;
            for (int i = 0; i < 2; i++) lane_q[i] <= LnHunt;
            dsk_q     <= DsIdle;
            skew_q    <= '0;
            first_q   <= 1'b0;
            sel0_q    <= '0;
            sel1_q    <= '0;
            rx_en_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                sr_q[i]   <= {sr_q[i][6:0], din[i]};
                lane_q[i] <= lane_d[i];
            end
            bit_cnt_q <= bit_cnt_d;
            com_cnt_q <= com_cnt_d;
            dsk_q     <= dsk_d;
            skew_q    <= skew_d;
            first_q   <= first_d;
            sel0_q    <= sel0_d;
            sel1_q    <= sel1_d;
            rx_en_q   <= (dsk_q == DsDone) && !realign;
            err_q     <= err_now && !realign;
        end
    end

    assign lane_locked = {lane_q[1] == LnLocked, lane_q[0] == LnLocked};
    assign delay_sel_0 = sel0_q;
    assign delay_sel_1 = sel1_q;
    assign rx_enable   = rx_en_q;
    assign deskew_err  = err_q;
    assign byte_strobe = (dsk_q == DsDone) && boundary[~first_q];

endmodule
